// File: rtl/mio_responder.sv
// Memory/IO responder for the CPU data-memory handshake: one request at a time,
// served from word RAM or a small IO register file, completed by a MIO_ready pulse.
module mio_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        MIO_ready,
  output logic        addr_err,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mio_req_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  mio_req_t          req_in, req_q, cmt;
  logic              commit;
  logic              sel_ram, sel_io;
  logic [1:0]        io_off;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       rd_data;
  logic [31:0]       cyc, scratch;
  logic [15:0]       sw_s1, sw_s2;
  logic [31:0]       ram [2**ADDR_W];
  logic              unused_bits;

  assign req_in = '{we: mem_w, addr: data_addr, wdata: data_out};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (CPU_MIO) begin
        cnt_nx   = LAT_M1;
        state_nx = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is the acceptance edge, so use the live request.
  assign cmt    = (state == IDLE) ? req_in : req_q;
  assign commit = rst && (state != RESP) && (state_nx == RESP);

  assign sel_ram = (cmt.addr[31:28] == 4'h0);
  assign sel_io  = (cmt.addr[31:28] == 4'hF);
  assign io_off  = cmt.addr[3:2];
  assign widx    = cmt.addr[ADDR_W+1:2];

  always_comb begin
    rd_data = '0;
    if (sel_ram) rd_data = ram[widx];
    else if (sel_io) begin
      case (io_off)
        2'd0:    rd_data = {16'h0, led};
        2'd1:    rd_data = {16'h0, sw_s2};
        2'd2:    rd_data = cyc;
        default: rd_data = scratch;
      endcase
    end
  end

  assign MIO_ready = (state == RESP);
  assign addr_err  = (state == RESP) &&
                     !((req_q.addr[31:28] == 4'h0) || (req_q.addr[31:28] == 4'hF));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      data_in <= '0;
      led     <= '0;
      scratch <= '0;
      cyc     <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cyc   <= cyc + 32'd1;
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      if (state == IDLE && CPU_MIO) req_q <= req_in;
      if (commit) begin
        if (cmt.we) begin
          if (sel_io && io_off == 2'd0) led     <= cmt.wdata[15:0];
          if (sel_io && io_off == 2'd3) scratch <= cmt.wdata;
        end else begin
          data_in <= rd_data;
        end
      end
    end
  end

  // RAM contents survive reset; commit already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (commit && cmt.we && sel_ram) ram[widx] <= cmt.wdata;
  end

  assign unused_bits = ^{req_q, cmt};

endmodule
